// File: rtl/lampFPU_pkg.sv
// Shared bfloat16 widths, canonical NaN and packed exception-flag type for the log datapath.
package lampFPU_pkg;

  localparam int LAMP_FLOAT_S_DW = 1;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;
  localparam int LAMP_FLOAT_DW   = LAMP_FLOAT_S_DW + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;

  localparam logic [LAMP_FLOAT_DW-1:0] LAMP_CANON_NAN = 16'h7FC0;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
  } lampLogFlags_t;

endpackage

// File: rtl/lamp_fpu_round_core.sv
// Combinational round-to-fraction and special-result select for the log result path.
module lamp_fpu_round_core
  import lampFPU_pkg::*;
#(
  parameter logic [LAMP_FLOAT_DW-1:0] CANON_NAN = LAMP_CANON_NAN
) (
  input  logic [LAMP_FLOAT_S_DW-1:0] s_i,
  input  logic [LAMP_FLOAT_E_DW-1:0] e_i,
  input  logic [LAMP_FLOAT_F_DW-1:0] f_i,
  input  logic                       isToRound_i,
  input  logic                       isOverflow_i,
  input  logic                       isUnderflow_i,
  input  logic                       isNaN_i,
  input  logic                       isInf_i,
  input  logic                       isZ_i,
  output logic [LAMP_FLOAT_S_DW-1:0] s_o,
  output logic [LAMP_FLOAT_E_DW-1:0] e_o,
  output logic [LAMP_FLOAT_F_DW-1:0] f_o,
  output lampLogFlags_t              flags_o
);

  logic [LAMP_FLOAT_F_DW:0]   sum;
  logic                       carry;
  logic [LAMP_FLOAT_E_DW-1:0] e_rnd;
  logic [LAMP_FLOAT_F_DW-1:0] f_rnd;

  // Rounding carry out of the fraction bumps the exponent and leaves a zero fraction.
  assign sum   = {1'b0, f_i} + {{LAMP_FLOAT_F_DW{1'b0}}, isToRound_i};
  assign carry = sum[LAMP_FLOAT_F_DW];
  assign f_rnd = carry ? '0 : sum[LAMP_FLOAT_F_DW-1:0];
  assign e_rnd = e_i + {{(LAMP_FLOAT_E_DW-1){1'b0}}, carry};

  always_comb begin
    s_o     = s_i;
    e_o     = e_rnd;
    f_o     = f_rnd;
    flags_o = '0;
    if (isNaN_i) begin
      s_o = CANON_NAN[LAMP_FLOAT_DW-1];
      e_o = CANON_NAN[LAMP_FLOAT_DW-2:LAMP_FLOAT_F_DW];
      f_o = CANON_NAN[LAMP_FLOAT_F_DW-1:0];
    end else if (isInf_i) begin
      e_o = '1;
      f_o = '0;
    end else if (isOverflow_i || (&e_rnd)) begin
      e_o         = '1;
      f_o         = '0;
      flags_o.ovf = 1'b1;
      flags_o.inx = 1'b1;
    end else if (isUnderflow_i) begin
      e_o         = '0;
      f_o         = '0;
      flags_o.unf = 1'b1;
      flags_o.inx = 1'b1;
    end else if (isZ_i) begin
      e_o = '0;
      f_o = '0;
    end else begin
      flags_o.inx = isToRound_i;
    end
  end

endmodule

// File: rtl/lamp_fpu_log_round.sv
// Two-stage rounding/packing tail of the log unit with valid/ready flow control.
// Optional sticky exception flags enabled by LAMP_LOG_ROUND_FLAGS_EN.
module lamp_fpu_log_round
  import lampFPU_pkg::*;
#(
  parameter logic [LAMP_FLOAT_DW-1:0] CANON_NAN = LAMP_CANON_NAN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [LAMP_FLOAT_S_DW-1:0] s_i,
  input  logic [LAMP_FLOAT_E_DW-1:0] e_i,
  input  logic [LAMP_FLOAT_F_DW-1:0] f_i,
  input  logic                       isToRound_i,
  input  logic                       isOverflow_i,
  input  logic                       isUnderflow_i,
  input  logic                       isNaN_i,
  input  logic                       isInf_i,
  input  logic                       isZ_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [LAMP_FLOAT_DW-1:0]   res_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  output logic                       inexact_o,
  input  logic                       clear_flags_i,
  output logic [2:0]                 flags_o
);

  logic [1:0] vld_pipe_q;  // [0] = S1 occupied, [1] = S2 occupied
  logic       adv_s1, adv_s2;

  logic [LAMP_FLOAT_S_DW-1:0] rnd_s, s1_s_q;
  logic [LAMP_FLOAT_E_DW-1:0] rnd_e, s1_e_q;
  logic [LAMP_FLOAT_F_DW-1:0] rnd_f, s1_f_q;
  lampLogFlags_t              rnd_flags, s1_flags_q, s2_flags_q;
  logic [LAMP_FLOAT_DW-1:0]   res_d, res_q;

  assign adv_s2  = !vld_pipe_q[1] || ready_i;
  assign adv_s1  = !vld_pipe_q[0] || adv_s2;
  assign ready_o = adv_s1;
  assign res_d   = {s1_s_q, s1_e_q, s1_f_q};

  lamp_fpu_round_core #(.CANON_NAN(CANON_NAN)) u_core (
    .s_i          (s_i),
    .e_i          (e_i),
    .f_i          (f_i),
    .isToRound_i  (isToRound_i),
    .isOverflow_i (isOverflow_i),
    .isUnderflow_i(isUnderflow_i),
    .isNaN_i      (isNaN_i),
    .isInf_i      (isInf_i),
    .isZ_i        (isZ_i),
    .s_o          (rnd_s),
    .e_o          (rnd_e),
    .f_o          (rnd_f),
    .flags_o      (rnd_flags)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      s1_s_q     <= '0;
      s1_e_q     <= '0;
      s1_f_q     <= '0;
      s1_flags_q <= '0;
      res_q      <= '0;
      s2_flags_q <= '0;
    end else begin
      if (adv_s1) begin
        vld_pipe_q[0] <= valid_i;
        if (valid_i) begin
          s1_s_q     <= rnd_s;
          s1_e_q     <= rnd_e;
          s1_f_q     <= rnd_f;
          s1_flags_q <= rnd_flags;
        end
      end
      // Output registers only move when the consumer has taken the current result.
      if (adv_s2) begin
        vld_pipe_q[1] <= vld_pipe_q[0];
        if (vld_pipe_q[0]) begin
          res_q      <= res_d;
          s2_flags_q <= s1_flags_q;
        end
      end
    end
  end

  assign valid_o     = vld_pipe_q[1];
  assign res_o       = res_q;
  assign overflow_o  = s2_flags_q.ovf;
  assign underflow_o = s2_flags_q.unf;
  assign inexact_o   = s2_flags_q.inx;

`ifdef LAMP_LOG_ROUND_FLAGS_EN
  lampLogFlags_t sticky_d, sticky_q;

  // A flag raised by a delivered result survives a same-cycle clear.
  assign sticky_d = (clear_flags_i ? lampLogFlags_t'('0) : sticky_q)
                  | ((valid_o && ready_i) ? s2_flags_q : lampLogFlags_t'('0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sticky_q <= '0;
    else      sticky_q <= sticky_d;
  end

  assign flags_o = sticky_q;
`else
  logic unused_clear;
  assign unused_clear = clear_flags_i;
  assign flags_o      = '0;
`endif

endmodule

// File: tb/tb_lamp_fpu_log_round.sv
// Self-checking bench for lamp_fpu_log_round: directed vectors, backpressure, reset, random traffic.
module tb_lamp_fpu_log_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0, ready_o;
  logic        s_i = 1'b0;
  logic [7:0]  e_i = '0;
  logic [6:0]  f_i = '0;
  logic        isToRound_i = 1'b0, isOverflow_i = 1'b0, isUnderflow_i = 1'b0;
  logic        isNaN_i = 1'b0, isInf_i = 1'b0, isZ_i = 1'b0;
  logic        valid_o, ready_i = 1'b1;
  logic [15:0] res_o;
  logic        overflow_o, underflow_o, inexact_o;
  logic        clear_flags_i = 1'b0;
  logic [2:0]  flags_o;

  int errors = 0;
  int checks = 0;

  logic [18:0] sbq[$];        // {res, ovf, unf, inx} in delivery order
  logic [2:0]  flg_m = '0;    // expected sticky flags
  logic        prev_stall = 1'b0;
  logic [18:0] prev_out = '0;

  always #5 clk = ~clk;

  lamp_fpu_log_round dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .s_i(s_i), .e_i(e_i), .f_i(f_i),
    .isToRound_i(isToRound_i), .isOverflow_i(isOverflow_i), .isUnderflow_i(isUnderflow_i),
    .isNaN_i(isNaN_i), .isInf_i(isInf_i), .isZ_i(isZ_i),
    .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o), .inexact_o(inexact_o),
    .clear_flags_i(clear_flags_i), .flags_o(flags_o)
  );

  function automatic logic [18:0] model(input logic s, input logic [7:0] e, input logic [6:0] f,
                                        input logic r, input logic nan, input logic inf,
                                        input logic ovf, input logic unf, input logic z);
    int fr, er;
    fr = int'(f) + int'(r);
    er = int'(e);
    if (fr == 128) begin fr = 0; er = er + 1; end
    if (nan)              return {16'h7FC0, 3'b000};
    if (inf)              return {s, 8'hFF, 7'h00, 3'b000};
    if (ovf || er >= 255) return {s, 8'hFF, 7'h00, 3'b101};
    if (unf)              return {s, 15'h0000, 3'b011};
    if (z)                return {s, 15'h0000, 3'b000};
    return {s, 8'(er), 7'(fr), 2'b00, r};
  endfunction

  task automatic set_in(input logic s, input logic [7:0] e, input logic [6:0] f, input logic r,
                        input logic nan, input logic inf, input logic ovf, input logic unf,
                        input logic z);
    valid_i = 1'b1; s_i = s; e_i = e; f_i = f; isToRound_i = r;
    isNaN_i = nan; isInf_i = inf; isOverflow_i = ovf; isUnderflow_i = unf; isZ_i = z;
  endtask

  task automatic rand_in();
    int k;
    logic [7:0] e;
    logic [6:0] f;
    k = $urandom_range(0, 7);
    e = (k == 0) ? 8'd254 : (k == 1) ? 8'd0 : 8'($urandom_range(1, 253));
    f = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom);
    set_in(1'($urandom), e, f, 1'($urandom),
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
  endtask

  // One clock of traffic; inputs were driven at the preceding negedge.
  task automatic cycle();
    logic [18:0] exp;
    logic        hs;
    #1;
    checks++;
    if (flags_o !== flg_m) begin
      errors++; $display("FAIL sticky_flags got=%b exp=%b", flags_o, flg_m);
    end
    checks++;
    if (ready_o !== !(sbq.size() == 2 && !ready_i)) begin
      errors++; $display("FAIL ready_o got=%b inflight=%0d ready_i=%b", ready_o, sbq.size(), ready_i);
    end
    if (prev_stall) begin
      checks++;
      if (valid_o !== 1'b1 || {res_o, overflow_o, underflow_o, inexact_o} !== prev_out) begin
        errors++; $display("FAIL hold valid=%b out=%h exp=%h", valid_o, {res_o, overflow_o, underflow_o, inexact_o}, prev_out);
      end
    end
    hs  = valid_o && ready_i;
    exp = '0;
    if (hs) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++; $display("FAIL spurious_output res=%h", res_o);
      end else begin
        exp = sbq.pop_front();
        if ({res_o, overflow_o, underflow_o, inexact_o} !== exp) begin
          errors++; $display("FAIL result got=%h/%b%b%b exp=%h/%b", res_o, overflow_o, underflow_o, inexact_o, exp[18:3], exp[2:0]);
        end
      end
    end
`ifdef LAMP_LOG_ROUND_FLAGS_EN
    flg_m = (clear_flags_i ? 3'b000 : flg_m) | (hs ? exp[2:0] : 3'b000);
`endif
    if (valid_i && ready_o)
      sbq.push_back(model(s_i, e_i, f_i, isToRound_i, isNaN_i, isInf_i, isOverflow_i, isUnderflow_i, isZ_i));
    prev_stall = valid_o && !ready_i;
    prev_out   = {res_o, overflow_o, underflow_o, inexact_o};
    @(negedge clk);
  endtask

  task automatic drain();
    valid_i = 1'b0; ready_i = 1'b1; clear_flags_i = 1'b0;
    for (int i = 0; i < 10 && sbq.size() > 0; i++) cycle();
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL drain_timeout pending=%0d exp=0", sbq.size());
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    checks++;
    if ({valid_o, res_o, overflow_o, underflow_o, inexact_o, flags_o} !== '0) begin
      errors++; $display("FAIL reset_state valid=%b res=%h flags=%b exp=0", valid_o, res_o, flags_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b exp=1", ready_o);
    end
    @(negedge clk);
  endtask

  // Single vector, ready_i high: checks 2-cycle latency and the literal result.
  task automatic run_vec(input string name, input logic [15:0] exp_res, input logic [2:0] exp_fl);
    ready_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL %s_lat1 valid_o=%b exp=0", name, valid_o);
    end
    cycle();
    #1;
    checks++;
    if (valid_o !== 1'b1 || res_o !== exp_res || {overflow_o, underflow_o, inexact_o} !== exp_fl) begin
      errors++; $display("FAIL %s valid=%b res=%h fl=%b exp res=%h fl=%b", name, valid_o, res_o, {overflow_o, underflow_o, inexact_o}, exp_res, exp_fl);
    end
    cycle();
  endtask

  task automatic test_directed();
    set_in(1'b0, 8'd126, 7'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("vec_normal", 16'h3F55, 3'b000);
    set_in(1'b0, 8'd126, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("vec_carry", 16'h3F80, 3'b001);
    valid_i = 1'b0; clear_flags_i = 1'b1;
    cycle();
    clear_flags_i = 1'b0;
    set_in(1'b0, 8'd254, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("vec_overflow", 16'h7F80, 3'b101);
    #1;
    checks++;
`ifdef LAMP_LOG_ROUND_FLAGS_EN
    if (flags_o !== 3'b101) begin
      errors++; $display("FAIL vec_overflow_sticky got=%b exp=101", flags_o);
    end
`else
    if (flags_o !== 3'b000) begin
      errors++; $display("FAIL flags_tied got=%b exp=000", flags_o);
    end
`endif
    @(negedge clk);
    set_in(1'b1, 8'd10, 7'h12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_vec("vec_nan", 16'h7FC0, 3'b000);
    set_in(1'b1, 8'd40, 7'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_vec("vec_underflow", 16'h8000, 3'b011);
    set_in(1'b1, 8'd40, 7'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_vec("vec_inf", 16'hFF80, 3'b000);
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    logic acc;
    logic [7:0] es [3] = '{8'd100, 8'd101, 8'd102};
    for (int cyc = 0; cyc < 12; cyc++) begin
      ready_i = (cyc >= 4);
      if (idx < 3) set_in(1'b0, es[idx], 7'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      else         valid_i = 1'b0;
      #1;
      acc = valid_i && ready_o;
      if (cyc == 2) begin
        checks++;
        if (ready_o !== 1'b0 || idx != 2) begin
          errors++; $display("FAIL bp_ready_fall ready_o=%b accepts=%0d exp 0/2", ready_o, idx);
        end
      end
      cycle();
      if (acc) idx++;
    end
    checks++;
    if (idx != 3 || sbq.size() != 0) begin
      errors++; $display("FAIL bp_delivery accepts=%0d pending=%0d exp 3/0", idx, sbq.size());
    end
  endtask

  task automatic test_reset_midflight();
    ready_i = 1'b0;
    set_in(1'b0, 8'd254, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    set_in(1'b1, 8'd50, 7'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    valid_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({valid_o, res_o, overflow_o, underflow_o, inexact_o, flags_o} !== '0) begin
      errors++; $display("FAIL midflight_reset valid=%b res=%h flags=%b exp=0", valid_o, res_o, flags_o);
    end
    sbq.delete(); flg_m = '0; prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1; ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (valid_o !== 1'b0) begin
        errors++; $display("FAIL stale_after_reset cycle=%0d valid_o=%b exp=0", i, valid_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clear_vs_set();
    set_in(1'b0, 8'd3, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    drain();
    ready_i = 1'b0;
    set_in(1'b0, 8'd200, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    valid_i = 1'b0;
    cycle();
    ready_i = 1'b1; clear_flags_i = 1'b1;
    cycle();
    clear_flags_i = 1'b0;
    #1;
    checks++;
`ifdef LAMP_LOG_ROUND_FLAGS_EN
    if (flags_o !== 3'b101) begin
      errors++; $display("FAIL clear_vs_set got=%b exp=101", flags_o);
    end
`else
    if (flags_o !== 3'b000) begin
      errors++; $display("FAIL clear_vs_set_tied got=%b exp=000", flags_o);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) rand_in();
      else valid_i = 1'b0;
      ready_i       = ($urandom_range(0, 9) < 7);
      clear_flags_i = ($urandom_range(0, 19) == 0);
      cycle();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    drain();
    test_back_to_back();
    test_reset_midflight();
    test_clear_vs_set();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
